// File: rtl/resp_push_pkg.sv
// rtl/resp_push_pkg.sv - shared types, constants and helpers for the R-response push path
// Contents:
//   state_t          push FSM states (IDLE, PUSH, ERR)
//   RESP_OKAY/SLVERR AXI RRESP encodings
//   cnt_mode_t       up/down counter direction (UP, DOWN)
//   TRUE/FALSE       single-bit boolean constants for counter controls
//   beats_from_len   completion length in DW -> number of R beats
package resp_push_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } cnt_mode_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // A zero length field means the maximum encodable length (2**len_width DW).
    function automatic int unsigned beats_from_len(
        input int unsigned len,
        input int unsigned len_width,
        input int unsigned dw_per_beat
    );
        int unsigned len_dw;
        len_dw = (len == 0) ? (32'd1 << len_width) : len;
        return (len_dw + dw_per_beat - 1) / dw_per_beat;
    endfunction

endpackage

// File: rtl/resp_push_ctrl_if.sv
// rtl/resp_push_ctrl_if.sv - descriptor, data-buffer and R-FIFO signals of the push controller
// Signals:
//   cpl_*   completion descriptor handshake (valid/ready) and fields
//   buf_*   show-ahead completion data buffer (empty, head data, pop)
//   fifo_*  R-response FIFO push side (full, write enable, RID/RDATA/RRESP/RLAST)
// Modports:
//   master  the push controller
//   slave   the surrounding system (descriptor source, buffer, FIFO)
interface resp_push_ctrl_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 10
);
    logic                  cpl_valid;
    logic                  cpl_ready;
    logic [ID_WIDTH-1:0]   cpl_id;
    logic [LEN_WIDTH-1:0]  cpl_length;
    logic                  cpl_err;
    logic                  cpl_last;

    logic                  buf_empty;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  buf_rd_en;

    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic [ID_WIDTH-1:0]   fifo_id;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic [1:0]            fifo_resp;
    logic                  fifo_last;

    modport master (
        input  cpl_valid, cpl_id, cpl_length, cpl_err, cpl_last,
        input  buf_empty, buf_data, fifo_full,
        output cpl_ready, buf_rd_en,
        output fifo_wr_en, fifo_id, fifo_data, fifo_resp, fifo_last
    );

    modport slave (
        output cpl_valid, cpl_id, cpl_length, cpl_err, cpl_last,
        output buf_empty, buf_data, fifo_full,
        input  cpl_ready, buf_rd_en,
        input  fifo_wr_en, fifo_id, fifo_data, fifo_resp, fifo_last
    );
endinterface

// File: rtl/up_down_counter.sv
// rtl/up_down_counter.sv - loadable saturating up/down counter
// Ports:
//   clk, resetn  clock, synchronous active-low reset (clears count)
//   en           step one in the direction given by mode
//   load         load load_count (takes priority over en)
//   load_count   value to load
//   mode         UP or DOWN
//   count        current count
module up_down_counter
    import resp_push_pkg::*;
#(
    parameter int MAX_COUNT = 255,
    parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_count,
    input  cnt_mode_t        mode,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Saturates at 0 and MAX_COUNT so it can never wrap.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_count;
        end else if (en) begin
            if (mode == DOWN) begin
                if (count_q != '0) count_d = count_q - WIDTH'(1);
            end else begin
                if (count_q != WIDTH'(MAX_COUNT)) count_d = count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/resp_push_ctrl.sv
// rtl/resp_push_ctrl.sv - splits completions into AXI R beats and pushes them into the R FIFO
// Ports:
//   clk   clock
//   arst  synchronous active-low reset; all bus outputs are forced to 0 while low
//   bus   resp_push_ctrl_if.master: descriptor in, buffer pop, R FIFO push
module resp_push_ctrl
    import resp_push_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 10,
    parameter int CNT_WIDTH  = $clog2(1024 / (DATA_WIDTH / 32)) + 1
) (
    input  logic              clk,
    input  logic              arst,
    resp_push_ctrl_if.master  bus
);
    localparam int DW_PER_BEAT = DATA_WIDTH / 32;
    localparam int MAX_COUNT   = 2**CNT_WIDTH - 1;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  last_q, last_d;

    logic                  cnt_en;
    logic                  cnt_load;
    logic [CNT_WIDTH-1:0]  cnt_load_count;
    cnt_mode_t             cnt_mode;
    logic [CNT_WIDTH-1:0]  count;

    logic                  push;
    logic                  cpl_ready_o;
    logic                  buf_rd_en_o;
    logic                  fifo_wr_en_o;
    logic [ID_WIDTH-1:0]   fifo_id_o;
    logic [DATA_WIDTH-1:0] fifo_data_o;
    logic [1:0]            fifo_resp_o;
    logic                  fifo_last_o;

    up_down_counter #(
        .MAX_COUNT (MAX_COUNT),
        .WIDTH     (CNT_WIDTH)
    ) u_beat_cnt (
        .clk        (clk),
        .resetn     (arst),
        .en         (cnt_en),
        .load       (cnt_load),
        .load_count (cnt_load_count),
        .mode       (cnt_mode),
        .count      (count)
    );

    always_comb begin
        state_d        = state_q;
        id_d           = id_q;
        last_d         = last_q;
        cnt_en         = FALSE;
        cnt_load       = FALSE;
        cnt_load_count = '0;
        cnt_mode       = DOWN;
        push           = 1'b0;
        cpl_ready_o    = 1'b0;
        buf_rd_en_o    = 1'b0;
        fifo_wr_en_o   = 1'b0;
        fifo_id_o      = '0;
        fifo_data_o    = '0;
        fifo_resp_o    = RESP_OKAY;
        fifo_last_o    = 1'b0;

        case (state_q)
            IDLE: begin
                cpl_ready_o = 1'b1;
                if (bus.cpl_valid) begin
                    id_d           = bus.cpl_id;
                    last_d         = bus.cpl_last;
                    cnt_load       = TRUE;
                    cnt_load_count = CNT_WIDTH'(beats_from_len(32'(bus.cpl_length),
                                                               LEN_WIDTH, DW_PER_BEAT));
                    state_d        = bus.cpl_err ? ERR : PUSH;
                end
            end
            PUSH: begin
                // Buffer is show-ahead: the head word is valid whenever not empty,
                // so pop and push happen in the same cycle.
                push         = !bus.fifo_full && !bus.buf_empty;
                fifo_wr_en_o = push;
                buf_rd_en_o  = push;
                fifo_id_o    = id_q;
                fifo_data_o  = bus.buf_data;
                fifo_last_o  = last_q && (count == CNT_WIDTH'(1));
                cnt_en       = push;
                if (push && count == CNT_WIDTH'(1)) state_d = IDLE;
            end
            ERR: begin
                // Error completions carry no payload: one zero-data SLVERR beat
                // closes the response regardless of the request's last flag.
                fifo_wr_en_o = !bus.fifo_full;
                fifo_id_o    = id_q;
                fifo_resp_o  = RESP_SLVERR;
                fifo_last_o  = 1'b1;
                if (!bus.fifo_full) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Hold everything quiet while reset is asserted, even mid-burst.
        if (!arst) begin
            cnt_en       = FALSE;
            cnt_load     = FALSE;
            cpl_ready_o  = 1'b0;
            buf_rd_en_o  = 1'b0;
            fifo_wr_en_o = 1'b0;
            fifo_id_o    = '0;
            fifo_data_o  = '0;
            fifo_resp_o  = RESP_OKAY;
            fifo_last_o  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst) begin
            state_q <= IDLE;
            id_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign bus.cpl_ready  = cpl_ready_o;
    assign bus.buf_rd_en  = buf_rd_en_o;
    assign bus.fifo_wr_en = fifo_wr_en_o;
    assign bus.fifo_id    = fifo_id_o;
    assign bus.fifo_data  = fifo_data_o;
    assign bus.fifo_resp  = fifo_resp_o;
    assign bus.fifo_last  = fifo_last_o;
endmodule

// File: doc/resp_push_ctrl.md
Name: resp_push_ctrl

Overview:
Push FSM for the AXI slave response path. It accepts completion descriptors from the TL RX side and splits each completion payload into AXI R-channel beats. It pushes the beats from the show-ahead completion data buffer into the R-response FIFO. The remaining beat count is held in an instance of the shared up/down counter, which this block loads, enables and sets to down-count.

Parameters:
DATA_WIDTH, 256, AXI R data width in bits; must be a multiple of 32.
ID_WIDTH, 4, AXI ID width.
LEN_WIDTH, 10, completion length field in DW; value 0 encodes 1024 DW.
CNT_WIDTH, derived, $clog2(1024/(DATA_WIDTH/32))+1; width of the beat counter.

Ports:
clk  in  1  clock.
arst  in  1  reset; synchronous, active-low.
cpl_valid  in  1  completion descriptor valid.
cpl_ready  out  1  descriptor accepted when cpl_valid && cpl_ready.
cpl_id  in  ID_WIDTH  AXI ID of the owning request.
cpl_length  in  LEN_WIDTH  payload length in DW.
cpl_err  in  1  completion status UR/CA, carries no payload.
cpl_last  in  1  final completion of the AXI request.
buf_empty  in  1  completion data buffer empty.
buf_data  in  DATA_WIDTH  head-of-buffer data (show-ahead).
buf_rd_en  out  1  pop buffer head.
fifo_full  in  1  R FIFO full.
fifo_wr_en  out  1  push one R beat.
fifo_id  out  ID_WIDTH  RID.
fifo_data  out  DATA_WIDTH  RDATA.
fifo_resp  out  2  RRESP: 2'b00 OKAY, 2'b10 SLVERR.
fifo_last  out  1  RLAST.

Behaviour:
- Reset (arst=0 at a clk edge): state IDLE; counter cleared; latched id/err/last cleared. All outputs are 0 during and after reset.
- Beat count: beats = ceil(L / (DATA_WIDTH/32)), where L = cpl_length, or 1024 if cpl_length==0. DATA_WIDTH=256 gives 1..128 beats.
- States IDLE, PUSH, ERR.
- IDLE:
  - cpl_ready=1.
  - On accept: latch cpl_id and cpl_last, drive counter Load=1 with Load_Count=beats, Mode=DOWN.
  - Next state is ERR if cpl_err, else PUSH.
- PUSH:
  - cpl_ready=0.
  - push = !fifo_full && !buf_empty. Combinationally, fifo_wr_en = buf_rd_en = push.
  - fifo_data=buf_data, fifo_resp=OKAY, fifo_id=latched id.
  - Counter En=push, Mode=DOWN.
  - fifo_last = latched cpl_last && (count==1).
  - If push && count==1, next state is IDLE.
  - With no push, all state and the count hold (stall on full or empty).
- ERR:
  - Drives exactly one beat when !fifo_full: fifo_data=0, fifo_resp=SLVERR, fifo_last=1 regardless of cpl_last, buf_rd_en=0.
  - Next state is IDLE.
  - The buffer is never popped in ERR.
- Latency: one cycle from descriptor accept to the first possible push. There is one IDLE cycle between completions, so a 1-beat completion occupies 2 cycles.
- A descriptor is never accepted in PUSH or ERR; cpl_valid may stay high and is accepted on return to IDLE.
- Reset mid-burst: the burst is abandoned with no further pushes or pops. The system resets the buffer and FIFO together with this block.
- Counter never wraps: a decrement is only issued while count>=1.

Decomposition:
- Package resp_push_pkg holds:
  - enum state_t {IDLE, PUSH, ERR};
  - RESP_OKAY / RESP_SLVERR constants;
  - the shared counter mode enum (UP/DOWN) and boolean TRUE/FALSE, reused from the existing counter package;
  - a function beats_from_len(len).
- Sub-module: one instance of the existing up_down_counter, MAX_COUNT=2**CNT_WIDTH-1, with its En/Load/Load_Count/Mode driven by this FSM. No other sub-modules.

Test Plan:
- Length 16 DW, cpl_last=1, FIFO and buffer always ready -> 2 pushes on consecutive cycles starting 1 cycle after accept; fifo_last only on the 2nd; 2 buf_rd_en pulses.
- Length 3 DW, cpl_last=0 -> 1 push with fifo_last=0; cpl_ready returns to 1 the next cycle.
- Length 0 (1024 DW) -> exactly 128 pushes; fifo_last on beat 128; count reaches 0 with no underflow.
- Length 32 DW with fifo_full asserted for 3 cycles after beat 2 -> no push while full; count holds at 2; beats 3-4 resume; total 4 pushes.
- cpl_err=1 with length 8 -> one beat with RRESP=2'b10, RLAST=1, data 0; buf_rd_en never asserts.
- arst=0 after beat 5 of a 16-beat completion -> next edge gives IDLE with all outputs 0; a new length-8 completion then yields exactly 1 beat.
